// File: rtl/pm_boot_loader.sv
// pm_boot_loader
//   Fills program memory from a length-prefixed, checksummed byte stream
//   while holding the core stalled. Once the image is loaded and the
//   checksum matches, it releases the stall. A checksum mismatch latches
//   an error and keeps the core stalled.
//
//   Image format: CNT_HI CNT_LO | N words of B bytes, MSB first | CK
//   CK is the mod-256 sum of every byte before it, header included.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   in_dt        image byte from the upstream source
//   in_valid     in_dt is valid
//   in_ready     loader accepts a byte (transfer = in_valid & in_ready)
//   ldr_pm_cslt  program-memory chip select, one-cycle pulse per word
//   ldr_pm_wrb   program-memory write strobe, active low, only with cslt
//   ldr_pm_add   program-memory write address
//   ldr_pm_dt    program-memory write data
//   core_stallb  core stall control, active low (0 = stalled)
//   boot_done    image loaded and verified, sticky until reset
//   boot_err     checksum mismatch, sticky until reset
module pm_boot_loader #(
    parameter int PMA_SIZE  = 16,
    parameter int PMD_SIZE  = 32,
    parameter int PM_LOCATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_dt,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                ldr_pm_cslt,
    output logic                ldr_pm_wrb,
    output logic [PMA_SIZE-1:0] ldr_pm_add,
    output logic [PMD_SIZE-1:0] ldr_pm_dt,
    output logic                core_stallb,
    output logic                boot_done,
    output logic                boot_err
);

    localparam int B  = PMD_SIZE / 8;
    localparam int IW = (B > 1) ? $clog2(B) : 1;
    localparam logic [IW-1:0]       LAST_IDX = IW'(B - 1);
    localparam logic [PMA_SIZE-1:0] LOC      = PMA_SIZE'(PM_LOCATE);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_CKSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [15:0]           cnt_q;
    logic [IW-1:0]         idx_q;
    logic [7:0]            sum_q;
    logic [PMD_SIZE-1:0]   asm_q;
    logic [PMA_SIZE-1:0]   add_q;
    logic [PMD_SIZE-1:0]   dt_q;
    logic                  cslt_q;
    logic                  wrb_q;
    logic                  rdy_q;
    logic                  stallb_q;
    logic                  done_q;
    logic                  err_q;

    logic                  xfer;
    logic [7:0]            sum_d;
    logic [15:0]           cnt_d;
    logic [PMD_SIZE-1:0]   asm_d;

    // rdy_q is only ever 1 in the byte-accepting states, so a transfer
    // needs no further state qualification.
    assign xfer  = in_valid & rdy_q;
    assign sum_d = sum_q + in_dt;
    assign cnt_d = {cnt_q[15:8], in_dt};
    // Shift-in form also works when a word is a single byte.
    assign asm_d = (asm_q << 8) | PMD_SIZE'(in_dt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_HDR_HI;
            cnt_q    <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            asm_q    <= '0;
            add_q    <= LOC;
            dt_q     <= '0;
            cslt_q   <= 1'b0;
            wrb_q    <= 1'b1;
            rdy_q    <= 1'b0;
            stallb_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_HDR_HI: begin
                    // First edge after reset release raises in_ready here.
                    rdy_q <= 1'b1;
                    if (xfer) begin
                        cnt_q[15:8] <= in_dt;
                        sum_q       <= sum_d;
                        state_q     <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        cnt_q   <= cnt_d;
                        sum_q   <= sum_d;
                        state_q <= (cnt_d == 16'd0) ? S_CKSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        sum_q <= sum_d;
                        asm_q <= asm_d;
                        if (idx_q == LAST_IDX) begin
                            // Word complete: present it for exactly one cycle.
                            idx_q   <= '0;
                            dt_q    <= asm_d;
                            cslt_q  <= 1'b1;
                            wrb_q   <= 1'b0;
                            rdy_q   <= 1'b0;
                            state_q <= S_WRITE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Address advances only after the pulse, so it is stable
                    // for the whole write cycle; wraps naturally.
                    cslt_q  <= 1'b0;
                    wrb_q   <= 1'b1;
                    rdy_q   <= 1'b1;
                    add_q   <= add_q + 1'b1;
                    cnt_q   <= cnt_q - 16'd1;
                    state_q <= (cnt_q == 16'd1) ? S_CKSUM : S_DATA;
                end
                S_CKSUM: begin
                    if (xfer) begin
                        rdy_q <= 1'b0;
                        if (in_dt == sum_q) begin
                            done_q   <= 1'b1;
                            stallb_q <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERROR;
                        end
                    end
                end
                default: begin
                    // DONE / ERROR are terminal until reset.
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = rdy_q;
    assign ldr_pm_cslt = cslt_q;
    assign ldr_pm_wrb  = wrb_q;
    assign ldr_pm_add  = add_q;
    assign ldr_pm_dt   = dt_q;
    assign core_stallb = stallb_q;
    assign boot_done   = done_q;
    assign boot_err    = err_q;

endmodule

// File: tb/tb_pm_boot_loader.sv
module tb_pm_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_dt;
    logic        in_valid;

    logic        rdy0, cslt0, wrb0, stallb0, done0, err0;
    logic [15:0] add0;
    logic [31:0] dt0;
    logic        rdy1, cslt1, wrb1, stallb1, done1, err1;
    logic [15:0] add1;
    logic [31:0] dt1;

    always #5 clk = ~clk;

    pm_boot_loader #(.PMA_SIZE(16), .PMD_SIZE(32), .PM_LOCATE(0)) dut0 (
        .clk(clk), .reset(reset), .in_dt(in_dt), .in_valid(in_valid),
        .in_ready(rdy0), .ldr_pm_cslt(cslt0), .ldr_pm_wrb(wrb0),
        .ldr_pm_add(add0), .ldr_pm_dt(dt0), .core_stallb(stallb0),
        .boot_done(done0), .boot_err(err0)
    );

    // Same stream, located at the top of memory to exercise address wrap.
    pm_boot_loader #(.PMA_SIZE(16), .PMD_SIZE(32), .PM_LOCATE(16'hFFFF)) dut1 (
        .clk(clk), .reset(reset), .in_dt(in_dt), .in_valid(in_valid),
        .in_ready(rdy1), .ldr_pm_cslt(cslt1), .ldr_pm_wrb(wrb1),
        .ldr_pm_add(add1), .ldr_pm_dt(dt1), .core_stallb(stallb1),
        .boot_done(done1), .boot_err(err1)
    );

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;
    int bad0 = 0;
    int last_xfer;
    int we0, we1;

    logic [15:0] wa0[$];
    logic [31:0] wd0[$];
    int          wc0[$];
    logic [15:0] wa1[$];
    logic [31:0] wd1[$];

    logic [7:0] stream [11] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hBA};
    int gaps [11] = '{0, 3, 1, 5, 0, 2, 4, 0, 1, 5, 3};

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (cslt0) begin
            wa0.push_back(add0);
            wd0.push_back(dt0);
            wc0.push_back(cyc);
            if (wrb0 !== 1'b0 || rdy0 !== 1'b0) bad0++;
        end else if (wrb0 !== 1'b1) begin
            bad0++;
        end
        if (cslt1) begin
            wa1.push_back(add1);
            wd1.push_back(dt1);
            if (wrb1 !== 1'b0) bad0++;
        end else if (wrb1 !== 1'b1) begin
            bad0++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        if (obs !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_dt    = b;
        t = 0;
        while (rdy0 !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("rdy_timeout", {63'd0, rdy0}, 64'd1);
        last_xfer = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] ck, input bit use_gaps);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) chk("done_before_ck", {63'd0, done0}, 64'd0);
            send((i == 10) ? ck : stream[i], use_gaps ? gaps[i] : 0);
            if (i == 5) we0 = last_xfer;
            if (i == 9) we1 = last_xfer;
        end
    endtask

    task automatic check_writes(input int n0, input int n1, input int b0);
        chk("nwr0", 64'(wa0.size() - n0), 64'd2);
        chk("nwr1", 64'(wa1.size() - n1), 64'd2);
        chk("strobe", 64'(bad0 - b0), 64'd0);
        if (wa0.size() >= n0 + 2 && wa1.size() >= n1 + 2) begin
            chk("add0_w0", 64'(wa0[n0]),     64'h0000);
            chk("dt0_w0",  64'(wd0[n0]),     64'h11223344);
            chk("add0_w1", 64'(wa0[n0 + 1]), 64'h0001);
            chk("dt0_w1",  64'(wd0[n0 + 1]), 64'hAABBCCDD);
            chk("t_w0",    64'(wc0[n0]),     64'(we0 + 1));
            chk("t_w1",    64'(wc0[n0 + 1]), 64'(we1 + 1));
            chk("add1_w0", 64'(wa1[n1]),     64'hFFFF);
            chk("dt1_w0",  64'(wd1[n1]),     64'h11223344);
            chk("add1_w1", 64'(wa1[n1 + 1]), 64'h0000);
            chk("dt1_w1",  64'(wd1[n1 + 1]), 64'hAABBCCDD);
        end
    endtask

    task automatic check_done();
        chk("done0",   {63'd0, done0},   64'd1);
        chk("stallb0", {63'd0, stallb0}, 64'd1);
        chk("err0",    {63'd0, err0},    64'd0);
        chk("rdy_end", {63'd0, rdy0},    64'd0);
        chk("done1",   {63'd0, done1},   64'd1);
    endtask

    task automatic check_reset_vals();
        chk("rst_rdy",    {63'd0, rdy0},    64'd0);
        chk("rst_cslt",   {63'd0, cslt0},   64'd0);
        chk("rst_wrb",    {63'd0, wrb0},    64'd1);
        chk("rst_add0",   64'(add0),        64'h0000);
        chk("rst_dt",     64'(dt0),         64'h0);
        chk("rst_stallb", {63'd0, stallb0}, 64'd0);
        chk("rst_done",   {63'd0, done0},   64'd0);
        chk("rst_err",    {63'd0, err0},    64'd0);
        chk("rst_add1",   64'(add1),        64'hFFFF);
        chk("rst_rdy1",   {63'd0, rdy1},    64'd0);
        chk("rst_misc1",  {61'd0, stallb1, done1, err1}, 64'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rdy_rise", {63'd0, rdy0}, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        release_reset();
    endtask

    initial begin
        int n0, n1, b0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_dt    = 8'h00;
        @(negedge clk);
        check_reset_vals();
        release_reset();

        // Normal load, no gaps; in_valid held high across WRITE.
        n0 = wa0.size(); n1 = wa1.size(); b0 = bad0;
        send_stream(8'hBA, 1'b0);
        check_done();
        repeat (5) @(negedge clk);
        check_writes(n0, n1, b0);

        // Zero word count.
        do_reset();
        n0 = wa0.size(); b0 = bad0;
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        repeat (3) @(negedge clk);
        chk("zero_nwr",    64'(wa0.size() - n0), 64'd0);
        chk("zero_done",   {63'd0, done0},   64'd1);
        chk("zero_stallb", {63'd0, stallb0}, 64'd1);

        // Bad checksum, then extra bytes that must be ignored.
        do_reset();
        n0 = wa0.size(); n1 = wa1.size(); b0 = bad0;
        send_stream(8'hBB, 1'b0);
        in_valid = 1'b1;
        in_dt    = 8'h55;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check_writes(n0, n1, b0);
        chk("bad_err",    {63'd0, err0},    64'd1);
        chk("bad_done",   {63'd0, done0},   64'd0);
        chk("bad_stallb", {63'd0, stallb0}, 64'd0);
        chk("bad_rdy",    {63'd0, rdy0},    64'd0);

        // Source gaps, including across the write cycle.
        do_reset();
        n0 = wa0.size(); n1 = wa1.size(); b0 = bad0;
        send_stream(8'hBA, 1'b1);
        check_done();
        check_writes(n0, n1, b0);

        // Asynchronous reset mid-word, then a full reload.
        do_reset();
        for (int i = 0; i < 5; i++) send(stream[i], 0);
        chk("mid_rdy", {63'd0, rdy0}, 64'd1);
        #1 reset = 1'b0;
        #1 check_reset_vals();
        release_reset();
        n0 = wa0.size(); n1 = wa1.size(); b0 = bad0;
        send_stream(8'hBA, 1'b0);
        check_done();
        check_writes(n0, n1, b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
